// File: rtl/aes_128_key_expander.sv
// rtl/aes_128_key_expander.sv - iterative AES-128 key schedule, one round key per cycle; optional key store under AES_KEY_STORE_EN
module aes_128_key_expander #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key,
  input  logic         start,
  output logic         busy,
  output logic         rk_valid,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         done
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
`endif
);

  // Only the AES-128 schedule is implemented; refuse to elaborate anything else.
  if (ROUNDS != 10) begin : g_rounds_check
    $error("aes_128_key_expander supports ROUNDS == 10 only");
  end

  localparam logic [3:0] LAST = 4'(ROUNDS);

  // AES S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_EXPAND = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [127:0]  r_key;
  logic [3:0]    r_cnt;
  logic [7:0]    r_rcon;

  logic [31:0]   w_w0, w_w1, w_w2, w_w3;
  logic [31:0]   w_rot, w_sub;
  logic [31:0]   w_n0, w_n1, w_n2, w_n3;
  logic [7:0]    w_rcon_next;
  logic          w_accept;
  logic          w_last;

  assign w_w0 = r_key[127:96];
  assign w_w1 = r_key[95:64];
  assign w_w2 = r_key[63:32];
  assign w_w3 = r_key[31:0];

  assign w_rot = {w_w3[23:0], w_w3[31:24]};
  assign w_sub = {sub_byte(w_rot[31:24]), sub_byte(w_rot[23:16]),
                  sub_byte(w_rot[15:8]),  sub_byte(w_rot[7:0])};

  assign w_n0 = w_w0 ^ w_sub ^ {r_rcon, 24'h000000};
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_cnt == LAST);

  // Next-state decode: leave IDLE on start, return after the last round key.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (start)  w_next_state = S_EXPAND;
      S_EXPAND: if (w_last) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Working key, round counter and Rcon; they hold after the final round so rk/rk_idx stay visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_key  <= '0;
      r_cnt  <= '0;
      r_rcon <= 8'h01;
    end else if (w_accept) begin
      r_key  <= key;
      r_cnt  <= '0;
      r_rcon <= 8'h01;
    end else if (r_state == S_EXPAND && !w_last) begin
      r_key  <= {w_n0, w_n1, w_n2, w_n3};
      r_cnt  <= r_cnt + 4'd1;
      r_rcon <= w_rcon_next;
    end
  end

  assign busy     = (r_state == S_EXPAND);
  assign rk_valid = busy;
  assign rk       = r_key;
  assign rk_idx   = r_cnt;
  assign done     = busy && w_last;

`ifdef AES_KEY_STORE_EN
  logic [127:0] r_store [0:ROUNDS];

  // Capture every streamed round key at its own index; reset wipes the whole store.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= ROUNDS; i++) r_store[i] <= '0;
    end else if (rk_valid) begin
      r_store[rk_idx] <= rk;
    end
  end

  // Asynchronous read port; indices past the last round read as zero.
  always_comb begin
    rd_key = '0;
    if (rd_idx <= LAST) rd_key = r_store[rd_idx];
  end
`endif

endmodule

// File: tb/tb_aes_128_key_expander.sv
// tb/tb_aes_128_key_expander.sv - scoreboard bench for aes_128_key_expander
module tb_aes_128_key_expander;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key;
  logic         start;
  logic         busy;
  logic         rk_valid;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         done;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  aes_128_key_expander #(.ROUNDS(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key      (key),
    .start    (start),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk       (rk),
    .rk_idx   (rk_idx),
    .done     (done)
`ifdef AES_KEY_STORE_EN
    ,
    .rd_idx   (rd_idx),
    .rd_key   (rd_key)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  typedef struct {
    logic [127:0] rk;
    logic [3:0]   idx;
    logic         done;
  } exp_t;

  exp_t         sb_q[$];
  logic [7:0]   sbox_m [256];
  logic [127:0] last_rk [16];
  int           m_left = 0;
  bit           m_rst_chk = 1'b0;
  int           n_checks = 0;
  int           n_errors = 0;
  int           n_done = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box derived from GF(2^8) inversion plus the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_m[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic push_expansion(input logic [127:0] k);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    exp_t        e;
    {w0, w1, w2, w3} = k;
    rc = 8'h01;
    for (int r = 0; r <= 10; r++) begin
      e.rk = {w0, w1, w2, w3};
      e.idx = 4'(r);
      e.done = (r == 10);
      sb_q.push_back(e);
      t = {w3[23:0], w3[31:24]};
      t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
      w0 = w0 ^ t ^ {rc, 24'h0};
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
    end
  endtask

  // Monitor then model: compare the current cycle, then predict the coming edge from the driven inputs.
  always @(negedge clk) begin
    exp_t e;
    if (m_rst_chk) begin
      check("rst_busy", busy, 0);
      check("rst_valid", rk_valid, 0);
      check("rst_done", done, 0);
      check("rst_rk", rk, 0);
      check("rst_idx", rk_idx, 0);
    end else begin
      check("busy", busy, m_left != 0);
      check("rk_valid", rk_valid, m_left != 0);
      if (rk_valid) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          check("rk_idx", rk_idx, e.idx);
          check("rk", rk, e.rk);
          check("done", done, e.done);
          last_rk[rk_idx] = rk;
          if (done) n_done++;
        end
      end else begin
        check("done_idle", done, 0);
      end
    end
    m_rst_chk = !rst_n;
    if (!rst_n) begin
      m_left = 0;
      sb_q.delete();
    end else if (m_left == 0 && start) begin
      push_expansion(key);
      m_left = 11;
    end else if (m_left > 0) begin
      m_left--;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_q.size() != 0 || m_left != 0) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) check("drain_timeout", n, 0);
  endtask

  task automatic run_one(input logic [127:0] k);
    key = k;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_drain();
  endtask

  initial begin
    int d0;
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    key = '0;
    rd_idx = '0;
    build_sbox();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    run_one(FIPS_KEY);
    check("fips_rk0", last_rk[0], FIPS_KEY);
    check("fips_rk1", last_rk[1], FIPS_RK1);
    check("fips_rk10", last_rk[10], FIPS_RK10);
    check("hold_busy", busy, 0);
    check("hold_rk", rk, FIPS_RK10);
    check("hold_idx", rk_idx, 10);
`ifdef AES_KEY_STORE_EN
    rd_idx = 4'd1;  #1; check("store_rd1", rd_key, FIPS_RK1);
    rd_idx = 4'd10; #1; check("store_rd10", rd_key, FIPS_RK10);
    rd_idx = 4'd15; #1; check("store_rd15", rd_key, 0);
`endif

    run_one('0);
    check("zero_rk1", last_rk[1], ZERO_RK1);
    check("zero_rk10", last_rk[10], ZERO_RK10);

    d0 = n_done;
    key = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    for (int i = 0; i < 36; i++) begin
      tick();
      if (i % 12 == 5) key = {$urandom, $urandom, $urandom, $urandom};
    end
    start = 1'b0;
    wait_drain();
    check("held_done_count", n_done - d0, 3);

    key = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(rk_valid && rk_idx == 4'd5) && n < 30) begin
      tick();
      n++;
    end
    if (n >= 30) check("idx5_timeout", n, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_rk", rk, 0);
`ifdef AES_KEY_STORE_EN
    rd_idx = 4'd10; #1; check("store_rst_rd10", rd_key, 0);
`endif
    tick();
    run_one({$urandom, $urandom, $urandom, $urandom});

    check("final_queue", sb_q.size(), 0);
    check("total_done", n_done, 6);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_128_key_expander.md
# aes_128_key_expander

Iterative AES-128 key schedule placed directly upstream of `aes_128_encryptor`. It accepts a 128-bit cipher key on a start pulse and produces the 11 round keys (round 0 to round 10), one per clock cycle, with a valid/index/done strobe. These keys feed the encryptor's per-round AddRoundKey. It contains its own 4-byte SubWord S-box lookup and has no dependency on the encryptor's internals.

## Interface
Parameters:
- `ROUNDS`, default 10: number of expansion rounds. Only 10 (AES-128) is supported; any other value is a compile-time error.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `key`, in, 128: cipher key; `key[127:120]` is byte 0, per FIPS-197 order. Sampled only when `start` is accepted.
- `start`, in, 1: request to begin expansion. Accepted only when `busy`=0.
- `busy`, out, 1: expansion in progress.
- `rk_valid`, out, 1: `rk`/`rk_idx` carry a valid round key this cycle.
- `rk`, out, 128: current round key, same byte order as `key`.
- `rk_idx`, out, 4: round index, 0..10.
- `done`, out, 1: one-cycle pulse, coincident with round 10.
- `rd_idx`, in, 4: key-store read index. Present only with `AES_KEY_STORE_EN`.
- `rd_key`, out, 128: key-store read data. Present only with `AES_KEY_STORE_EN`.

## Operation
- States:
  - IDLE: `busy`=0. `start`=1 moves to EXPAND, loads `key` into the working register, sets the round counter to 0 and Rcon to 0x01.
  - EXPAND: outputs the working key as round key `rk_idx`.
    - If counter<10: compute the next key, increment the counter, step Rcon.
    - If counter=10: assert `done` and return to IDLE.
- Next-key words, with w0 = bits [127:96]:
  - n0 = w0 ^ SubWord(RotWord(w3)) ^ {Rcon, 24'h0}
  - n1 = w1 ^ n0
  - n2 = w2 ^ n1
  - n3 = w3 ^ n2
- RotWord is a left rotate by one byte. SubWord applies the AES S-box to each of the 4 bytes.
- Rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. It is an 8-bit xtime: shift left, then XOR 0x1B if bit 7 was set.
- `start` while `busy`=1 is ignored. `key` changes during EXPAND have no effect.
- Reset at any time, including mid-expansion, has these effects at the next edge:
  - state goes to IDLE;
  - `busy`, `rk_valid` and `done` go to 0;
  - `rk` goes to 0 and `rk_idx` goes to 0;
  - Rcon goes to 0x01;
  - any key store is cleared to 0.

## Timing
- Outputs are registered; there are no combinational input-to-output paths except `rd_key` (see Configuration).
- `start` is sampled high at edge E0. At edges E1..E11, `rk_valid`=1 and `rk_idx`=0..10. `rk` for round 0 equals `key`.
- `busy`=1 from E1 through the E11 cycle. `done`=1 only in the E11 cycle.
- At E12, `busy`, `rk_valid` and `done` are 0 and `rk`/`rk_idx` hold their last values.
- Earliest next accepted `start` is sampled at E12. The minimum issue interval is 12 cycles.
- `start` high in the E11 cycle (`busy`=1) is ignored.
- `rk_valid` is never high while `busy`=0.

## Configuration
- `AES_KEY_STORE_EN` defined:
  - An 11×128-bit register file captures `rk` at index `rk_idx` on every `rk_valid` cycle.
  - `rd_key` = store[`rd_idx`] combinationally.
  - `rd_idx` > 10 returns 0.
  - Contents persist until the next expansion overwrites them, or until reset clears them.
- `AES_KEY_STORE_EN` not defined:
  - The `rd_idx`/`rd_key` ports and the store are absent.
  - Only the streaming outputs exist.
  - Streaming behaviour is identical in both builds.

## Test plan
- FIPS-197 key `2b7e151628aed2a6abf7158809cf4f3c`, start pulse. Required response:
  - E1: `rk` = key, idx 0.
  - E2: `a0fafe1788542cb123a339392a6c7605`, idx 1.
  - E11: `d014f9a8c9ee2589e13f0cc8b6630ca6`, idx 10, `done`=1.
  - E12: `busy`=0.
- All-zero key. Required response:
  - idx 1 = `62636363626363636263636362636363`.
  - idx 10 = `b4ef5bcb3e92e21123e951cf6f8f188e`.
- `start` held high continuously. Required response:
  - expansions begin at E0, E12, E24;
  - exactly one `done` per 12 cycles;
  - a `key` change mid-run does not alter the current sequence.
- `rst_n`=0 in the cycle with `rk_idx`=5. Required response:
  - next edge: all outputs 0, IDLE;
  - a new `start` then produces a full 0..10 sequence with Rcon restarting at 0x01.
- With `AES_KEY_STORE_EN`, after the FIPS-197 run:
  - `rd_idx`=1 gives `a0fafe17…7605`;
  - `rd_idx`=10 gives `d014f9a8…0ca6`;
  - `rd_idx`=15 gives 0.
- With `AES_KEY_STORE_EN`, reset after a run, then `rd_idx`=10 → 0.
